drv_segment_scan: RTL and testbench

Multiplexed multi-digit 7-segment display driver with a parametrised digit count. It converts a packed BCD word into time-multiplexed segment and anode drive for common-anode displays. Segments and anodes are active-low, with an anti-ghosting blank gap between digits. New values are buffered and transferred only on frame boundaries, so a frame never shows a mix of old and new digits. The block sits between application logic and the board display pins.

---
 rtl/drv_segment_pkg.sv | 35 +++
 rtl/drv_segment_tick.sv | 49 ++++
 rtl/drv_segment_scan.sv | 132 +++++++++++++
 tb/tb_drv_segment_scan.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/drv_segment_pkg.sv
// drv_segment_pkg
// Shared types and helpers for the multiplexed 7-segment driver.
//   seg_t      : 7-bit active-low segment pattern, bit0 = a (top) .. bit6 = g (middle)
//   SEG_BLANK  : all segments off
//   SEG_DEC    : active-low patterns for decimal digits 0..9
//   seg_decode : nibble -> pattern; non-decimal nibbles (10..15) decode to blank
package drv_segment_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    localparam seg_t SEG_DEC [0:9] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

    function automatic seg_t seg_decode(input logic [3:0] nibble);
        seg_t seg;
        seg = SEG_BLANK;
        if (nibble <= 4'd9) begin
            seg = SEG_DEC[nibble];
        end
        return seg;
    endfunction

endpackage

// File: rtl/drv_segment_tick.sv
// drv_segment_tick
// Slot/frame timebase for the segment scanner: a prescaler counting
// 0..PRESCALE-1 and a digit index counting 0..DIGITS-1.
// Ports:
//   i_clk, i_rst_n  : clock, asynchronous active-low reset
//   o_slot_end      : prescaler at terminal count (last cycle of a slot)
//   o_frame_start   : first cycle of slot 0 (prescaler 0, index 0)
//   o_idx           : current digit index
//   o_in_gap        : prescaler inside the anti-ghosting blank window
module drv_segment_tick #(
    parameter int DIGITS    = 8,
    parameter int PRESCALE  = 50000,
    parameter int BLANK_CYC = 500,
    parameter int IW        = 3
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    output logic          o_slot_end,
    output logic          o_frame_start,
    output logic [IW-1:0] o_idx,
    output logic          o_in_gap
);

    localparam int CW = $clog2(PRESCALE);

    logic [CW-1:0] cnt_reg;
    logic [IW-1:0] idx_reg;
    logic          last_digit;

    assign o_slot_end    = (cnt_reg == CW'(PRESCALE - 1));
    assign last_digit    = (idx_reg == IW'(DIGITS - 1));
    assign o_frame_start = (cnt_reg == '0) && (idx_reg == '0);
    assign o_in_gap      = (cnt_reg < CW'(BLANK_CYC));
    assign o_idx         = idx_reg;

    // With DIGITS = 1 last_digit is always true, so the index stays at 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_reg <= '0;
            idx_reg <= '0;
        end else if (o_slot_end) begin
            cnt_reg <= '0;
            idx_reg <= last_digit ? '0 : idx_reg + 1'b1;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/drv_segment_scan.sv
// drv_segment_scan
// Multiplexed multi-digit common-anode 7-segment driver. A packed BCD word
// is captured into a pending buffer and moved to the display register only
// at frame boundaries, so one frame never mixes old and new digits.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_val          : packed BCD, nibble k -> digit k (digit 0 least significant)
//   i_dp           : decimal point request per digit (active-high)
//   i_load         : capture strobe for i_val/i_dp
//   o_pend         : pending buffer holds data not yet displayed
//   o_frame        : one-cycle pulse on the first output cycle of slot 0
//   o_drv_sgmnt    : segments a..g, active-low
//   o_drv_dp       : decimal point, active-low
//   o_drv_an       : anode select, active-low one-hot
// Build option: define DRV_SEGMENT_LZB_EN for leading-zero blanking.
module drv_segment_scan
    import drv_segment_pkg::*;
#(
    parameter int DIGITS    = 8,
    parameter int PRESCALE  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [4*DIGITS-1:0]   i_val,
    input  logic [DIGITS-1:0]     i_dp,
    input  logic                  i_load,
    output logic                  o_pend,
    output logic                  o_frame,
    output logic [6:0]            o_drv_sgmnt,
    output logic                  o_drv_dp,
    output logic [DIGITS-1:0]     o_drv_an
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic          slot_end;
    logic          frame_start;
    logic [IW-1:0] idx;
    logic          in_gap;
    logic          frame_wrap;

    drv_segment_tick #(
        .DIGITS    (DIGITS),
        .PRESCALE  (PRESCALE),
        .BLANK_CYC (BLANK_CYC),
        .IW        (IW)
    ) u_tick (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .o_slot_end    (slot_end),
        .o_frame_start (frame_start),
        .o_idx         (idx),
        .o_in_gap      (in_gap)
    );

    // The clock edge on which the index wraps to 0 is the frame transfer edge.
    assign frame_wrap = slot_end && (idx == IW'(DIGITS - 1));

    logic [4*DIGITS-1:0] pbuf_val_reg;
    logic [DIGITS-1:0]   pbuf_dp_reg;
    logic [4*DIGITS-1:0] disp_val_reg;
    logic [DIGITS-1:0]   disp_dp_reg;
    logic                pend_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pbuf_val_reg <= '0;
            pbuf_dp_reg  <= '0;
            disp_val_reg <= '0;
            disp_dp_reg  <= '0;
            pend_reg     <= 1'b0;
        end else if (frame_wrap) begin
            // A load landing on the transfer edge skips the buffer entirely.
            if (i_load) begin
                disp_val_reg <= i_val;
                disp_dp_reg  <= i_dp;
            end else if (pend_reg) begin
                disp_val_reg <= pbuf_val_reg;
                disp_dp_reg  <= pbuf_dp_reg;
            end
            pend_reg <= 1'b0;
        end else if (i_load) begin
            pbuf_val_reg <= i_val;
            pbuf_dp_reg  <= i_dp;
            pend_reg     <= 1'b1;
        end
    end

    logic [3:0]        nib [DIGITS];
    logic [DIGITS-1:0] blank;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
        assign nib[gi] = disp_val_reg[4*gi +: 4];
    end

`ifdef DRV_SEGMENT_LZB_EN
    // zero_from[k]: nibble k and every more significant nibble are zero.
    logic [DIGITS:1] zero_from;
    assign zero_from[DIGITS] = 1'b1;
    assign blank[0]          = 1'b0;
    for (genvar gi = 1; gi < DIGITS; gi++) begin : g_lzb
        assign zero_from[gi] = (nib[gi] == 4'd0) && zero_from[gi+1];
        assign blank[gi]     = zero_from[gi];
    end
`else
    assign blank = '0;
`endif

    seg_t              seg_next;
    logic [DIGITS-1:0] an_next;

    assign seg_next = blank[idx] ? SEG_BLANK : seg_decode(nib[idx]);
    assign an_next  = in_gap ? '1 : ~(DIGITS'(1) << idx);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_drv_sgmnt <= SEG_BLANK;
            o_drv_dp    <= 1'b1;
            o_drv_an    <= '1;
            o_frame     <= 1'b0;
        end else begin
            o_drv_sgmnt <= seg_next;
            o_drv_dp    <= ~disp_dp_reg[idx];
            o_drv_an    <= an_next;
            o_frame     <= frame_start;
        end
    end

    assign o_pend = pend_reg;

endmodule

// File: tb/tb_drv_segment_scan.sv
// tb_drv_segment_scan
// Randomized and directed stimulus for drv_segment_scan (DIGITS=4,
// PRESCALE=4, BLANK_CYC=1) checked against a cycle-count based reference
// model. Honours DRV_SEGMENT_LZB_EN when defined.
module tb_drv_segment_scan;

    localparam int D  = 4;
    localparam int P  = 4;
    localparam int B  = 1;
    localparam int FL = D * P;

    logic          i_clk;
    logic          i_rst_n;
    logic [15:0]   i_val;
    logic [3:0]    i_dp;
    logic          i_load;
    logic          o_pend;
    logic          o_frame;
    logic [6:0]    o_drv_sgmnt;
    logic          o_drv_dp;
    logic [3:0]    o_drv_an;

    drv_segment_scan #(
        .DIGITS    (D),
        .PRESCALE  (P),
        .BLANK_CYC (B)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_val       (i_val),
        .i_dp        (i_dp),
        .i_load      (i_load),
        .o_pend      (o_pend),
        .o_frame     (o_frame),
        .o_drv_sgmnt (o_drv_sgmnt),
        .o_drv_dp    (o_drv_dp),
        .o_drv_an    (o_drv_an)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Which segments light for each decimal digit.
    string seg_lit [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                            "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

    function automatic logic [6:0] ref_seg(input int d);
        logic [6:0] m;
        string      s;
        m = 7'h7F;
        if (d <= 9) begin
            s = seg_lit[d];
            for (int i = 0; i < s.len(); i++) begin
                m[s.getc(i) - 8'h61] = 1'b0;
            end
        end
        return m;
    endfunction

    // Reference state: n counts clock edges since reset release.
    int          n;
    logic [15:0] m_disp, m_pbuf;
    logic [3:0]  m_ddp, m_pdp;
    logic        m_pend;
    logic [6:0]  e_seg;
    logic        e_dp, e_frame;
    logic [3:0]  e_an;

    task automatic model_reset();
        n = 0; m_disp = '0; m_pbuf = '0; m_ddp = '0; m_pdp = '0; m_pend = 1'b0;
        e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_frame = 1'b0;
    endtask

    task automatic model_edge(input logic ld, input logic [15:0] v, input logic [3:0] d);
        int phase, slot, dig;
        phase   = n % P;
        slot    = (n / P) % D;
        dig     = int'((m_disp >> (4 * slot)) & 16'hF);
        e_seg   = ref_seg(dig);
`ifdef DRV_SEGMENT_LZB_EN
        if (slot > 0 && (m_disp >> (4 * slot)) == 16'd0) e_seg = 7'h7F;
`endif
        e_dp    = ~m_ddp[slot];
        e_an    = (phase < B) ? 4'hF : ~(4'd1 << slot);
        e_frame = (n % FL) == 0;
        if ((n + 1) % FL == 0) begin
            if (ld) begin
                m_disp = v; m_ddp = d;
            end else if (m_pend) begin
                m_disp = m_pbuf; m_ddp = m_pdp;
            end
            m_pend = 1'b0;
        end else if (ld) begin
            m_pbuf = v; m_pdp = d; m_pend = 1'b1;
        end
        n++;
    endtask

    task automatic compare_all();
        check("sgmnt", {9'd0, o_drv_sgmnt}, {9'd0, e_seg});
        check("dp",    {15'd0, o_drv_dp},   {15'd0, e_dp});
        check("an",    {12'd0, o_drv_an},   {12'd0, e_an});
        check("frame", {15'd0, o_frame},    {15'd0, e_frame});
        check("pend",  {15'd0, o_pend},     {15'd0, m_pend});
    endtask

    // Called at a negedge; drives one cycle of inputs and checks the result.
    task automatic run_cycle(input logic ld, input logic [15:0] v, input logic [3:0] d);
        i_load = ld; i_val = v; i_dp = d;
        if (ld) $display("load val=%h dp=%b edge=%0d", v, d, n);
        @(posedge i_clk);
        model_edge(ld, v, d);
        @(negedge i_clk);
        i_load = 1'b0;
        compare_all();
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) run_cycle(1'b0, 16'h0, 4'h0);
    endtask

    // Idle until the next edge to be taken is edge number t within a frame.
    task automatic idle_to(input int t);
        for (int i = 0; i < FL && (n % FL) != t; i++) run_cycle(1'b0, 16'h0, 4'h0);
    endtask

    function automatic logic [15:0] rand_val();
        logic [15:0] v;
        for (int k = 0; k < 4; k++)
            v[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        return v;
    endfunction

    initial begin
        i_rst_n = 1'b0; i_load = 1'b0; i_val = '0; i_dp = '0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            compare_all();
        end
        i_rst_n = 1'b1;

        idle(3);
        run_cycle(1'b1, 16'h1234, 4'b0100);
        idle(2 * FL);
        run_cycle(1'b1, 16'h0050, 4'b0000);
        idle(2 * FL);
        run_cycle(1'b1, 16'hAB09, 4'b0001);
        idle(2 * FL);

        // Two loads in one frame: only the newer is ever shown.
        idle_to(1);
        run_cycle(1'b1, 16'h1111, 4'b1111);
        idle_to(6);
        run_cycle(1'b1, 16'h2222, 4'b0010);
        idle(2 * FL);

        // Load exactly on the transfer edge bypasses the buffer.
        idle_to(FL - 1);
        run_cycle(1'b1, 16'h4321, 4'b1000);
        idle(FL + 2);

        // Random loads.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0)
                run_cycle(1'b1, rand_val(), 4'($urandom_range(0, 15)));
            else
                run_cycle(1'b0, 16'($urandom), 4'($urandom_range(0, 15)));
        end

        // Reset in the middle of slot 2.
        run_cycle(1'b1, 16'h9876, 4'b0101);
        idle_to(10);
        i_rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        for (int i = 0; i < 2; i++) begin
            @(negedge i_clk);
            compare_all();
        end
        i_rst_n = 1'b1;
        idle(2 * FL);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
